// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared types, defaults and expected-result helper for the FIR sample source
// Contents: state_t (IDLE/RUN/DRAIN/DONE), default N/DEPTH/CNT_W/TAPS/DRAIN_TO, expected_count().
package fir_stream_pkg;

    localparam int DEF_N        = 32;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TAPS     = 16;
    localparam int DEF_DRAIN_TO = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A filter with 'taps' coefficients emits one result per sample once its
    // delay line is full, so n samples yield n-taps+1 results (or none).
    function automatic logic [31:0] expected_count(input logic [31:0] n,
                                                   input logic [31:0] taps);
        return (n >= taps) ? (n - taps + 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/fir_stream_fifo.sv
// rtl/fir_stream_fifo.sv - synchronous first-word-fall-through sample FIFO
// Ports: clk, rst (sync, active-high); push/push_data write side; pop read side;
//        full/empty from the registered count; head = oldest entry, valid while !empty.
module fir_stream_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] head
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push against a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_source.sv
// rtl/fir_stream_source.sv - streams a counted batch of FIFO samples into the FIR filter and counts its results
// Ports: clk, rst (sync, active-high)
//        wr_valid/wr_data/wr_ready : sample push into the internal FIFO
//        start/num_samples         : begin a run of num_samples samples (IDLE only)
//        fir_enable/fir_x/fir_busy : filter input handshake, consume = fir_enable && !fir_busy
//        fir_valid                 : filter output strobe, counted into res_cnt
//        sent_cnt/res_cnt          : per-run counters, held after the run
//        done/err                  : one-cycle completion pulse, err on drain timeout
module fir_stream_source
    import fir_stream_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TAPS     = DEF_TAPS,
    parameter int DRAIN_TO = DEF_DRAIN_TO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [N-1:0]     wr_data,
    output logic             wr_ready,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    output logic             fir_enable,
    output logic [N-1:0]     fir_x,
    input  logic             fir_busy,
    input  logic             fir_valid,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] res_cnt,
    output logic             done,
    output logic             err
);

    localparam int                IDLE_W  = $clog2(DRAIN_TO + 1);
    localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(DRAIN_TO - 1);

    state_t            state_q;
    state_t            state_d;
    logic              err_q;
    logic              err_d;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  sent_q;
    logic [CNT_W-1:0]  res_q;
    logic [CNT_W-1:0]  expected;
    logic [IDLE_W-1:0] idle_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [N-1:0]      fifo_head;

    logic              consume;
    logic              start_ok;
    logic              last_sample;
    logic              drain_met;
    logic              drain_timeout;
    logic              count_valid;

    fir_stream_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (consume),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign wr_ready   = !fifo_full;
    // Underflow simply stalls the stream: enable drops while the FIFO is empty.
    assign fir_enable = (state_q == RUN) && !fifo_empty;
    assign fir_x      = fir_enable ? fifo_head : '0;
    assign consume    = fir_enable && !fir_busy;

    assign start_ok      = (state_q == IDLE) && start;
    assign expected      = CNT_W'(expected_count(32'(num_q), 32'(TAPS)));
    assign last_sample   = consume && ((sent_q + CNT_W'(1)) == num_q);
    assign drain_met     = (res_q == expected);
    assign drain_timeout = !fir_valid && (idle_q == TO_LAST);
    assign count_valid   = fir_valid && ((state_q == RUN) || (state_q == DRAIN));

    assign sent_cnt = sent_q;
    assign res_cnt  = res_q;
    assign done     = (state_q == DONE);
    assign err      = (state_q == DONE) && err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_sample) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Normal completion wins over a timeout landing in the same cycle.
                if (drain_met) begin
                    state_d = DONE;
                end else if (drain_timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            num_q   <= '0;
            sent_q  <= '0;
            res_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (start_ok) begin
                num_q  <= num_samples;
                sent_q <= '0;
                res_q  <= '0;
            end else begin
                if (consume) begin
                    sent_q <= sent_q + CNT_W'(1);
                end
                if (count_valid && (res_q != '1)) begin
                    res_q <= res_q + CNT_W'(1);
                end
            end
            // Consecutive DRAIN cycles without a result; cleared outside DRAIN.
            if ((state_q != DRAIN) || fir_valid) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_source.sv
// tb/tb_fir_stream_source.sv - self-checking bench for fir_stream_source against a queue-based reference model
module tb_fir_stream_source;

    localparam int N        = 32;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 16;
    localparam int TAPS     = 16;
    localparam int DRAIN_TO = 64;
    localparam int RES_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [N-1:0]     wr_data;
    logic             wr_ready;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             fir_enable;
    logic [N-1:0]     fir_x;
    logic             fir_busy;
    logic             fir_valid;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] res_cnt;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    fir_stream_source #(
        .N        (N),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W),
        .TAPS     (TAPS),
        .DRAIN_TO (DRAIN_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .start       (start),
        .num_samples (num_samples),
        .fir_enable  (fir_enable),
        .fir_x       (fir_x),
        .fir_busy    (fir_busy),
        .fir_valid   (fir_valid),
        .sent_cnt    (sent_cnt),
        .res_cnt     (res_cnt),
        .done        (done),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 streaming, 2 waiting for results, 3 done pulse.
    int unsigned  m_q[$];
    int           m_ph;
    int           m_num;
    int           m_sent;
    int           m_res;
    int           m_idle;
    bit           m_err;
    logic [N-1:0] dut_seen[$];
    int           dut_done_cnt = 0;

    function automatic int exp_results(input int n);
        return (n >= TAPS) ? (n - TAPS + 1) : 0;
    endfunction

    // Called at a falling edge: compare outputs, drive inputs, advance the model over the next rising edge.
    task automatic step(input bit wv, input int unsigned wd, input bit st, input int num,
                        input bit busy, input bit val);
        bit          en;
        bit          c;
        bit          pushed;
        int unsigned front;
        int          e;
        en    = (m_ph == 1) && (m_q.size() > 0);
        front = 0;
        if (en) front = m_q[0];
        check_eq("wr_ready",   64'(wr_ready),   64'(m_q.size() < DEPTH));
        check_eq("fir_enable", 64'(fir_enable), 64'(en));
        check_eq("fir_x",      64'(fir_x),      64'(front));
        check_eq("sent_cnt",   64'(sent_cnt),   64'(m_sent));
        check_eq("res_cnt",    64'(res_cnt),    64'(m_res));
        check_eq("done",       64'(done),       64'(m_ph == 3));
        check_eq("err",        64'(err),        64'((m_ph == 3) && m_err));
        if (done === 1'b1) dut_done_cnt++;
        if (fir_enable === 1'b1 && !busy) dut_seen.push_back(fir_x);
        wr_valid    = wv;
        wr_data     = wd;
        start       = st;
        num_samples = CNT_W'(num);
        fir_busy    = busy;
        fir_valid   = val;
        c      = en && !busy;
        pushed = wv && (m_q.size() < DEPTH);
        if (c) void'(m_q.pop_front());
        if (pushed) m_q.push_back(wd);
        e = exp_results(m_num);
        case (m_ph)
            0: if (st) begin
                m_num = num; m_sent = 0; m_res = 0; m_err = 0;
                m_ph  = (num == 0) ? 3 : 1;
            end
            1: begin
                if (val && m_res < RES_MAX) m_res++;
                if (c) begin
                    m_sent++;
                    if (m_sent == m_num) begin m_ph = 2; m_idle = 0; end
                end
            end
            2: begin
                if (m_res == e) m_ph = 3;
                else if (!val && m_idle == DRAIN_TO - 1) begin m_ph = 3; m_err = 1; end
                m_idle = val ? 0 : m_idle + 1;
                if (val && m_res < RES_MAX) m_res++;
            end
            default: m_ph = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; start = 1'b0; fir_busy = 1'b0; fir_valid = 1'b0;
        wr_data = '0; num_samples = '0;
        @(negedge clk);
        rst = 1'b0;
        m_q.delete(); m_ph = 0; m_num = 0; m_sent = 0; m_res = 0; m_idle = 0; m_err = 0;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_val(input int unsigned v);
        step(1, v, 0, 0, 0, 0);
    endtask

    task automatic start_run(input int num);
        step(0, 0, 1, num, 0, 0);
    endtask

    task automatic stream_plain(input int want_sent);
        for (int k = 0; k < 200 && m_ph == 1; k++) step(0, 0, 0, 0, 0, 0);
        check_eq("stream_sent", 64'(sent_cnt), 64'(want_sent));
    endtask

    // Runs the current batch to completion with random pushes/busy and results fed in DRAIN.
    task automatic drive_run(input int p_push, input int p_busy, input int p_valid);
        int d0;
        bit wv;
        bit b;
        bit v;
        d0 = dut_done_cnt;
        for (int k = 0; k < 3000 && m_ph != 0; k++) begin
            wv = ($urandom_range(99) < p_push);
            b  = ($urandom_range(99) < p_busy);
            v  = (m_ph == 2) && (m_res < exp_results(m_num)) && ($urandom_range(99) < p_valid);
            step(wv, $urandom, 0, 0, b, v);
        end
        check_eq("done_pulses", 64'(dut_done_cnt - d0), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned want[$];
        int unsigned v;
        int          stalled;
        int          busy_left;
        int          k;
        int          d0;
        bit          wv;
        bit          b;

        do_reset();
        check_eq("rst_wr_ready", 64'(wr_ready),   64'd1);
        check_eq("rst_enable",   64'(fir_enable), 64'd0);
        check_eq("rst_done",     64'(done),       64'd0);
        check_eq("rst_sent",     64'(sent_cnt),   64'd0);

        // Preload 1..16, a dropped 17th push, then a full-rate stream of 16.
        for (int i = 1; i <= 16; i++) push_val(i);
        check_eq("full_wr_ready", 64'(wr_ready), 64'd0);
        push_val(99);
        dut_seen.delete();
        start_run(16);
        check_eq("t1_first_x", 64'(fir_x), 64'd1);
        stream_plain(16);
        check_eq("t1_count", 64'(dut_seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < dut_seen.size(); i++)
            check_eq("t1_order", 64'(dut_seen[i]), 64'(i + 1));
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t1_done", 64'(done),    64'd1);
        check_eq("t1_err",  64'(err),     64'd0);
        check_eq("t1_res",  64'(res_cnt), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        check_eq("idle_valid_ignored", 64'(res_cnt), 64'd1);
        idle_steps(1);

        // Busy stalls on every 4th sample while pushes overlap pops.
        dut_seen.delete(); want.delete();
        for (int i = 0; i < 8; i++) begin v = $urandom; want.push_back(v); push_val(v); end
        start_run(16);
        stalled = -1; busy_left = 0; k = 0;
        while (m_ph == 1 && k < 200) begin
            v  = $urandom;
            wv = (want.size() < 16);
            if (m_q.size() > 0 && m_sent % 4 == 3 && stalled != m_sent) begin
                stalled = m_sent; busy_left = 3;
            end
            b = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            step(wv, v, 0, 0, b, 0);
            if (wv) want.push_back(v);
            k++;
        end
        check_eq("t2_sent", 64'(sent_cnt), 64'd16);
        drive_run(0, 0, 100);
        check_eq("t2_count", 64'(dut_seen.size()), 64'd16);
        for (int i = 0; i < 16 && i < dut_seen.size(); i++)
            check_eq("t2_order", 64'(dut_seen[i]), 64'(want[i]));

        // Underflow: 8 requested, 4 queued, remaining 4 pushed later.
        dut_seen.delete();
        for (int i = 1; i <= 4; i++) push_val(i);
        start_run(8);
        idle_steps(8);
        check_eq("t3_stall_enable", 64'(fir_enable), 64'd0);
        check_eq("t3_stall_sent",   64'(sent_cnt),   64'd4);
        for (int i = 5; i <= 8; i++) push_val(i);
        stream_plain(8);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t3_short_done", 64'(done),    64'd1);
        check_eq("t3_short_res",  64'(res_cnt), 64'd0);
        idle_steps(1);
        check_eq("t3_count", 64'(dut_seen.size()), 64'd8);
        for (int i = 0; i < 8 && i < dut_seen.size(); i++)
            check_eq("t3_order", 64'(dut_seen[i]), 64'(i + 1));

        // Zero-length run and a run shorter than the tap count.
        start_run(0);
        check_eq("t5_zero_done", 64'(done), 64'd1);
        idle_steps(1);
        for (int i = 0; i < 10; i++) push_val($urandom);
        start_run(10);
        stream_plain(10);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t5_ten_done", 64'(done),    64'd1);
        check_eq("t5_ten_res",  64'(res_cnt), 64'd0);
        idle_steps(1);

        // Drain timeout with no results at all.
        for (int i = 0; i < 16; i++) push_val($urandom);
        start_run(16);
        stream_plain(16);
        k = 0;
        while (k < 100 && done !== 1'b1) begin step(0, 0, 0, 0, 0, 0); k++; end
        check_eq("t6_timeout_cycles", 64'(k),   64'd64);
        check_eq("t6_timeout_err",    64'(err), 64'd1);
        idle_steps(1);

        // Reset in the middle of a run.
        for (int i = 0; i < 8; i++) push_val($urandom);
        start_run(8);
        idle_steps(3);
        d0 = dut_done_cnt;
        do_reset();
        check_eq("mid_rst_enable", 64'(fir_enable), 64'd0);
        check_eq("mid_rst_x",      64'(fir_x),      64'd0);
        check_eq("mid_rst_sent",   64'(sent_cnt),   64'd0);
        check_eq("mid_rst_ready",  64'(wr_ready),   64'd1);
        idle_steps(5);
        check_eq("mid_rst_no_done", 64'(dut_done_cnt - d0), 64'd0);
        start_run(1);
        check_eq("mid_rst_fifo_empty", 64'(fir_enable), 64'd0);
        push_val($urandom);
        drive_run(0, 0, 100);

        // Randomised runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = $urandom_range(16); i > 0; i--) push_val($urandom);
            start_run($urandom_range(40, 1));
            drive_run(50, 30, 60);
            idle_steps($urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
